// File: rtl/reg_file_pkg.sv
// Shared widths and types for the MIPS general-purpose register file.
package reg_file_pkg;
  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 32;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;
endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two zero-latency combinational read ports, one clocked write port, r0 reads zero.
// Optional macro REG_FILE_BYPASS_EN forwards same-cycle write data to matching read ports.
module reg_file
  import reg_file_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  reg_addr_t read1,
  input  reg_addr_t read2,
  input  reg_data_t write_data,
  input  logic      write_reg,
  input  reg_addr_t write1,
  output reg_data_t reg1,
  output reg_data_t reg2
);

  reg_data_t mem_q [NUM_REGS];
  logic      wr_en_d;

  // A write with X address/data is harmless as long as write_reg is 0.
  assign wr_en_d = write_reg && (write1 != ZERO_REG);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_en_d) begin
      mem_q[write1] <= write_data;
    end
  end

  always_comb begin
    reg1 = '0;
    reg2 = '0;
    if (!rst) begin
      if (read1 != ZERO_REG) reg1 = mem_q[read1];
      if (read2 != ZERO_REG) reg2 = mem_q[read2];
`ifdef REG_FILE_BYPASS_EN
      if (wr_en_d && (read1 == write1)) reg1 = write_data;
      if (wr_en_d && (read2 == write1)) reg2 = write_data;
`endif
    end
  end

endmodule

// File: tb/tb_reg_file.sv
// Randomized plus directed check of reg_file against an array-based reference model.
module tb_reg_file;
  import reg_file_pkg::*;

  logic      clk = 1'b0;
  logic      rst;
  reg_addr_t read1, read2, write1;
  reg_data_t write_data;
  logic      write_reg;
  reg_data_t reg1, reg2;

  int n_tests = 0;
  int n_fail  = 0;
  reg_data_t model [NUM_REGS];

  reg_file dut (
    .clk(clk), .rst(rst), .read1(read1), .read2(read2),
    .write_data(write_data), .write_reg(write_reg), .write1(write1),
    .reg1(reg1), .reg2(reg2)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input reg_data_t got, input reg_data_t exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic void clear_model();
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
  endfunction

  // What a read port should show right now, from the architectural rules.
  function automatic reg_data_t expect_rd(input reg_addr_t a);
    if (rst || a == 0) return '0;
`ifdef REG_FILE_BYPASS_EN
    if (write_reg === 1'b1 && write1 === a) return write_data;
`endif
    return model[a];
  endfunction

  task automatic do_write(input reg_addr_t a, input reg_data_t d);
    @(negedge clk);
    write_reg = 1'b1; write1 = a; write_data = d;
    @(posedge clk);
    if (a != 0) model[a] = d;
    #1 write_reg = 1'b0;
  endtask

  initial begin
    rst = 1'b1; write_reg = 1'b0; write1 = '0; write_data = '0;
    read1 = 5'd5; read2 = 5'd31;
    clear_model();
    #12;
    check("reset_rd1", reg1, 32'h0);
    check("reset_rd2", reg2, 32'h0);
    @(negedge clk); rst = 1'b0;

    // Async reset pulse mid-cycle
    do_write(5'd1, 32'hDEAD_BEEF);
    @(negedge clk);
    read1 = 5'd0; read2 = 5'd1;
    #1 check("preload_r1", reg2, 32'hDEAD_BEEF);
    rst = 1'b1;
    #1 check("rstpulse_rd1", reg1, 32'h0);
    check("rstpulse_rd2", reg2, 32'h0);
    rst = 1'b0; clear_model();
    #1 check("after_rst_r1", reg2, 32'h0);

    // Register 0 discards writes
    do_write(5'd0, 32'h0);
    do_write(5'd0, 32'h3);
    read1 = 5'd0;
    #1 check("zero_reg", reg1, 32'h0);

    // Basic write/read
    do_write(5'd1, 32'h0000_0005);
    do_write(5'd31, 32'hFFFF_FFFF);
    read1 = 5'd1; read2 = 5'd31;
    #1 check("basic_r1", reg1, 32'h5);
    check("basic_r31", reg2, 32'hFFFF_FFFF);
    read2 = 5'd1;
    #1 check("same_addr_p1", reg1, 32'h5);
    check("same_addr_p2", reg2, 32'h5);

    // Write disabled
    @(negedge clk);
    write_reg = 1'b0; write1 = 5'd2; write_data = 32'h7;
    repeat (3) @(posedge clk);
    #1 read2 = 5'd2;
    #1 check("wr_disable", reg2, 32'h0);

    // Read during write
    do_write(5'd4, 32'd10);
    @(negedge clk);
    read1 = 5'd4; write_reg = 1'b1; write1 = 5'd4; write_data = 32'd20;
    #1;
`ifdef REG_FILE_BYPASS_EN
    check("rdw_before", reg1, 32'd20);
`else
    check("rdw_before", reg1, 32'd10);
`endif
    @(posedge clk);
    model[4] = 32'd20;
    #1 check("rdw_after", reg1, 32'd20);
    write_reg = 1'b0;

    // Reset coincident with a write edge
    @(negedge clk);
    write_reg = 1'b1; write1 = 5'd6; write_data = 32'd9;
    @(posedge clk);
    rst = 1'b1;
    #2 rst = 1'b0; write_reg = 1'b0; clear_model();
    read1 = 5'd6;
    #1 check("rst_vs_write", reg1, 32'h0);

    // Randomized traffic, including X inputs while write is disabled
    for (int it = 0; it < 400; it++) begin
      @(negedge clk);
      write_reg = $urandom_range(0, 1);
      if (!write_reg && $urandom_range(0, 3) == 0) begin
        write1 = 'x; write_data = 'x;
      end else begin
        write1 = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
        write_data = $urandom;
      end
      read1 = ($urandom_range(0, 3) == 0 && !$isunknown(write1)) ? write1
              : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      read2 = ($urandom_range(0, 3) == 0) ? read1
              : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
      #2;
      check("rand_pre_rd1", reg1, expect_rd(read1));
      check("rand_pre_rd2", reg2, expect_rd(read2));
      @(posedge clk);
      if (write_reg === 1'b1 && write1 != 0) model[write1] = write_data;
      #1;
      check("rand_post_rd1", reg1, expect_rd(read1));
    end

    // Sweep every register against the model
    @(negedge clk); write_reg = 1'b0;
    for (int a = 0; a < NUM_REGS; a++) begin
      read1 = reg_addr_t'(a);
      read2 = reg_addr_t'(NUM_REGS - 1 - a);
      #1;
      check("sweep_rd1", reg1, (a == 0) ? 32'h0 : model[a]);
      check("sweep_rd2", reg2, (a == NUM_REGS - 1) ? 32'h0 : model[NUM_REGS - 1 - a]);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
